// File: rtl/commit_trace_queue.sv
// commit_trace_queue
//    In-order buffer of per-cycle commit records between the core trace taps
//    and the co-simulation checker. A record whose write data comes back later
//    on the long-latency writeback port stays pending until that data lands,
//    and a pending head holds back every younger record.
//
//    Optional feature: define COMMIT_TRACE_QUEUE_TIMEOUT_EN to build the
//    pending-head watchdog that drives err_timeout. Without it err_timeout is 0.
//
// Ports
//    clock, reset            rising-edge clock, synchronous active-low reset
//    in_valid / in_*         commit record tapped this cycle
//    in_wait                 write data follows on the long-latency port
//    ll_wen/ll_waddr/ll_wdata long-latency writeback
//    out_valid / out_ready   head-record stream to the checker
//    out_hartid/pc/inst/wdata head-record fields
//    count                   occupied slots, 0..DEPTH
//    err_overflow            sticky, a record was dropped while full
//    err_orphan              sticky, a writeback matched no pending record
//    err_timeout             sticky, pending head waited TIMEOUT cycles
module commit_trace_queue #(
   parameter int DEPTH   = 16,
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [7:0]               in_hartid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_inst,
   input  logic [XLEN-1:0]          in_wdata,
   input  logic [4:0]               in_rd,
   input  logic                     in_wait,
   input  logic                     ll_wen,
   input  logic [4:0]               ll_waddr,
   input  logic [XLEN-1:0]          ll_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_hartid,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_inst,
   output logic [XLEN-1:0]          out_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_overflow,
   output logic                     err_orphan,
   output logic                     err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("commit_trace_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   logic [7:0]      hartid_q [DEPTH];
   logic [XLEN-1:0] pc_q     [DEPTH];
   logic [31:0]     inst_q   [DEPTH];
   logic [XLEN-1:0] wdata_q  [DEPTH];
   logic [4:0]      rd_q     [DEPTH];
   logic [DEPTH-1:0] pend_q;

   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic          err_overflow_q;
   logic          err_orphan_q;

   logic          full;
   logic          pop;
   logic          push;
   logic          push_pend;
   logic          ll_act;
   logic          fill_hit;
   logic [AW-1:0] fill_idx;
   logic [AW-1:0] scan_idx;

   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0) && !pend_q[head_q];
   assign pop       = out_valid && out_ready;
   // A pop frees the slot in the same cycle, so a full queue still accepts.
   assign push      = in_valid && (!full || pop);
   assign push_pend = in_wait && (in_rd != 5'd0);
   // x0 writebacks carry nothing to match and are silently ignored.
   assign ll_act    = ll_wen && (ll_waddr != 5'd0);

   // Oldest-first scan over the entries already queued; the record being
   // pushed this cycle is not yet visible, so a same-cycle writeback misses it.
   always_comb begin
      fill_hit = 1'b0;
      fill_idx = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + AW'(i);
         if (!fill_hit && ll_act && (CW'(i) < count_q) &&
             pend_q[scan_idx] && (rd_q[scan_idx] == ll_waddr)) begin
            fill_hit = 1'b1;
            fill_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         pend_q         <= '0;
         err_overflow_q <= 1'b0;
         err_orphan_q   <= 1'b0;
      end else begin
         if (pop) head_q <= head_q + AW'(1);
         if (push) begin
            tail_q         <= tail_q + AW'(1);
            pend_q[tail_q] <= push_pend;
         end
         // Never the tail slot: the fill target is queued, the tail is free
         // or is the head being popped, which cannot be pending.
         if (fill_hit) pend_q[fill_idx] <= 1'b0;
         count_q <= count_q + CW'(push) - CW'(pop);
         if (in_valid && !push) err_overflow_q <= 1'b1;
         if (ll_act && !fill_hit) err_orphan_q <= 1'b1;
      end
   end

   // Payload needs no reset; it is only observed through a valid head.
   always_ff @(posedge clock) begin
      if (push) begin
         hartid_q[tail_q] <= in_hartid;
         pc_q[tail_q]     <= in_pc;
         inst_q[tail_q]   <= in_inst;
         rd_q[tail_q]     <= in_rd;
         wdata_q[tail_q]  <= push_pend ? '0 : in_wdata;
      end
      if (fill_hit) wdata_q[fill_idx] <= ll_wdata;
   end

   assign out_hartid   = hartid_q[head_q];
   assign out_pc       = pc_q[head_q];
   assign out_inst     = inst_q[head_q];
   assign out_wdata    = wdata_q[head_q];
   assign count        = count_q;
   assign err_overflow = err_overflow_q;
   assign err_orphan   = err_orphan_q;

`ifdef COMMIT_TRACE_QUEUE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt_q;
   logic          err_timeout_q;
   logic          head_wait;

   assign head_wait = (count_q != '0) && pend_q[head_q];

   always_ff @(posedge clock) begin
      if (!reset) begin
         wd_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
      end else if (pop || fill_hit) begin
         wd_cnt_q <= '0;
      end else if (head_wait) begin
         // Saturates so a long stall cannot wrap back to zero.
         if (wd_cnt_q != TW'(TIMEOUT)) wd_cnt_q <= wd_cnt_q + TW'(1);
         if (wd_cnt_q == TW'(TIMEOUT - 1)) err_timeout_q <= 1'b1;
      end else begin
         wd_cnt_q <= '0;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_queue.sv
module tb_commit_trace_queue;

   localparam int DEPTH   = 4;
   localparam int XLEN    = 64;
   localparam int TIMEOUT = 8;

   logic            clock;
   logic            reset;
   logic            in_valid;
   logic [7:0]      in_hartid;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_wdata;
   logic [4:0]      in_rd;
   logic            in_wait;
   logic            ll_wen;
   logic [4:0]      ll_waddr;
   logic [XLEN-1:0] ll_wdata;
   logic            out_valid;
   logic            out_ready;
   logic [7:0]      out_hartid;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_inst;
   logic [XLEN-1:0] out_wdata;
   logic [$clog2(DEPTH):0] count;
   logic            err_overflow;
   logic            err_orphan;
   logic            err_timeout;

   commit_trace_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_hartid(in_hartid), .in_pc(in_pc),
      .in_inst(in_inst), .in_wdata(in_wdata), .in_rd(in_rd), .in_wait(in_wait),
      .ll_wen(ll_wen), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst),
      .out_wdata(out_wdata), .count(count),
      .err_overflow(err_overflow), .err_orphan(err_orphan),
      .err_timeout(err_timeout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of records, filled by searching it.
   typedef struct {
      logic [7:0]      h;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] wd;
      logic [4:0]      rd;
      bit              pend;
   } rec_t;

   rec_t mq[$];
   rec_t nr;
   bit   m_ovf, m_orph, m_to, started, m_pop, m_fill;
   int   m_wait;

   always @(posedge clock) begin
      if (!reset) begin
         mq.delete();
         m_ovf = 0; m_orph = 0; m_to = 0; m_wait = 0;
         started = 1;
      end else begin
         m_pop  = (mq.size() > 0) && !mq[0].pend && out_ready;
         m_fill = 0;
         if (ll_wen && ll_waddr != 0) begin
            for (int k = 0; k < mq.size(); k++) begin
               if (!m_fill && mq[k].pend && mq[k].rd == ll_waddr) begin
                  mq[k].wd   = ll_wdata;
                  mq[k].pend = 0;
                  m_fill     = 1;
               end
            end
            if (!m_fill) m_orph = 1;
         end
         if (m_pop || m_fill) m_wait = 0;
         else if (mq.size() > 0 && mq[0].pend) begin
            m_wait++;
`ifdef COMMIT_TRACE_QUEUE_TIMEOUT_EN
            if (m_wait == TIMEOUT) m_to = 1;
`endif
         end else m_wait = 0;
         if (m_pop) void'(mq.pop_front());
         if (in_valid) begin
            if (mq.size() < DEPTH) begin
               nr.h    = in_hartid;
               nr.pc   = in_pc;
               nr.inst = in_inst;
               nr.rd   = in_rd;
               nr.pend = in_wait && (in_rd != 0);
               nr.wd   = nr.pend ? '0 : in_wdata;
               mq.push_back(nr);
            end else m_ovf = 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (started) begin
         chk("count", 64'(count), 64'(mq.size()));
         chk("out_valid", 64'(out_valid), 64'((mq.size() > 0) && !mq[0].pend));
         chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
         chk("err_orphan", 64'(err_orphan), 64'(m_orph));
         chk("err_timeout", 64'(err_timeout), 64'(m_to));
         if (mq.size() > 0 && !mq[0].pend) begin
            chk("out_hartid", 64'(out_hartid), 64'(mq[0].h));
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
            chk("out_wdata", out_wdata, mq[0].wd);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      in_valid = 0;
      ll_wen   = 0;
   endtask

   task automatic set_push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] wd,
                           input logic [4:0] rd, input logic w);
      in_valid  = 1;
      in_pc     = pc;
      in_wdata  = wd;
      in_rd     = rd;
      in_wait   = w;
      in_inst   = 32'h00000013 ^ pc[31:0];
      in_hartid = pc[7:0] ^ 8'h5a;
   endtask

   task automatic set_ll(input logic [4:0] a, input logic [XLEN-1:0] d);
      ll_wen   = 1;
      ll_waddr = a;
      ll_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1);
   end

   initial begin
      reset = 0; in_valid = 0; ll_wen = 0; out_ready = 0;
      in_hartid = 0; in_pc = 0; in_inst = 0; in_wdata = 0; in_rd = 0; in_wait = 0;
      ll_waddr = 0; ll_wdata = 0;
      repeat (2) step();
      chk("reset_count", 64'(count), 64'd0);
      reset = 1;

      // Three records in flight, then reset discards them.
      for (int i = 0; i < 3; i++) begin
         set_push(64'h10 + 64'(4 * i), 64'(i), 5'd1, 0);
         step();
      end
      chk("inflight_count", 64'(count), 64'd3);
      reset = 0;
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_errs", 64'({err_overflow, err_orphan, err_timeout}), 64'd0);
      reset = 1;

      // Single complete record straight through.
      out_ready = 1;
      set_push(64'h8000_0000, 64'h5, 5'd2, 0);
      step();
      chk("simple_valid", 64'(out_valid), 64'd1);
      chk("simple_pc", out_pc, 64'h8000_0000);
      chk("simple_wdata", out_wdata, 64'h5);
      step();
      chk("simple_drain", 64'(count), 64'd0);

      // Load waits for its writeback and holds the younger ALU op behind it.
      set_push(64'h100, 64'h999, 5'd10, 1);
      step();
      chk("load_blocked", 64'(out_valid), 64'd0);
      set_push(64'h104, 64'h11, 5'd11, 0);
      step();
      step();
      chk("hol_block", 64'(out_valid), 64'd0);
      set_ll(5'd10, 64'hDEAD);
      step();
      chk("load_pc", out_pc, 64'h100);
      chk("load_wdata", out_wdata, 64'hDEAD);
      step();
      chk("alu_pc", out_pc, 64'h104);
      chk("alu_wdata", out_wdata, 64'h11);
      step();
      chk("order_drain", 64'(count), 64'd0);

      // Two writebacks to the same register fill oldest first.
      set_push(64'h200, 64'h0, 5'd5, 1);
      step();
      set_push(64'h204, 64'h0, 5'd5, 1);
      step();
      set_ll(5'd5, 64'h1);
      step();
      chk("same_rd_first_pc", out_pc, 64'h200);
      chk("same_rd_first_wd", out_wdata, 64'h1);
      set_ll(5'd5, 64'h2);
      step();
      chk("same_rd_second_pc", out_pc, 64'h204);
      chk("same_rd_second_wd", out_wdata, 64'h2);
      step();

      // x0 writeback ignored; unmatched writeback is an orphan.
      set_ll(5'd0, 64'h77);
      step();
      chk("x0_no_orphan", 64'(err_orphan), 64'd0);
      set_ll(5'd7, 64'h77);
      step();
      chk("orphan_set", 64'(err_orphan), 64'd1);
      reset = 0;
      step();
      reset = 1;
      chk("orphan_cleared", 64'(err_orphan), 64'd0);

      // Writeback in the same cycle as the matching push misses it.
      set_push(64'h250, 64'h0, 5'd3, 1);
      set_ll(5'd3, 64'h44);
      step();
      chk("samecyc_orphan", 64'(err_orphan), 64'd1);
      chk("samecyc_pending", 64'(out_valid), 64'd0);
      set_ll(5'd3, 64'h33);
      step();
      chk("samecyc_fill", out_wdata, 64'h33);
      step();

      // Overflow, then push-with-pop while full.
      out_ready = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         set_push(64'h300 + 64'(4 * i), 64'(i), 5'd4, 0);
         step();
      end
      chk("full_count", 64'(count), 64'(DEPTH));
      chk("overflow", 64'(err_overflow), 64'd1);
      chk("full_head", out_pc, 64'h300);
      out_ready = 1;
      set_push(64'h320, 64'h20, 5'd4, 0);
      step();
      chk("full_pushpop_count", 64'(count), 64'(DEPTH));
      chk("full_pushpop_head", out_pc, 64'h304);
      repeat (DEPTH) step();
      chk("full_drain", 64'(count), 64'd0);

      // Pending head with no writeback: watchdog.
      reset = 0;
      step();
      reset = 1;
      set_push(64'h400, 64'h0, 5'd9, 1);
      step();
      repeat (TIMEOUT - 1) step();
      chk("timeout_early", 64'(err_timeout), 64'd0);
      step();
`ifdef COMMIT_TRACE_QUEUE_TIMEOUT_EN
      chk("timeout_set", 64'(err_timeout), 64'd1);
`else
      chk("timeout_off", 64'(err_timeout), 64'd0);
`endif
      set_ll(5'd9, 64'h99);
      step();
      chk("timeout_fill", out_wdata, 64'h99);
      step();
      chk("final_count", 64'(count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/commit_trace_queue.md
# commit_trace_queue

Buffers per-cycle commit records tapped from the core's trace port and releases them in program order to the co-simulation checker through a valid/ready stream. A record whose destination write data arrives later over the long-latency writeback port is held pending until that data arrives. Only then is it released with the correct write value. The block sits between the pipeline trace taps in the testbench and the Dromajo comparison model, and it reports overflow and stuck-writeback errors to the testbench failure logic.

## Interface
- DEPTH, 16: number of record slots; power of two, at least 2.
- XLEN, 64: width of PC and write data.
- TIMEOUT, 4096: cycles a pending head may wait before `err_timeout` is raised; only used with the macro in Configuration.

Ports:
- clock  in  1  Sole clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-low reset (0 = reset), sampled on the rising edge of `clock`.
- in_valid  in  1  A commit record is presented this cycle.
- in_hartid  in  8  Hart ID of the commit.
- in_pc  in  XLEN  PC of the commit.
- in_inst  in  32  Instruction word.
- in_wdata  in  XLEN  Write data; ignored when `in_wait`=1.
- in_rd  in  5  Destination register.
- in_wait  in  1  Write data will arrive later over the long-latency writeback port.
- ll_wen  in  1  Long-latency writeback strobe.
- ll_waddr  in  5  Register written by the long-latency writeback.
- ll_wdata  in  XLEN  Value written by the long-latency writeback.
- out_valid  out  1  The head record is complete.
- out_ready  in  1  The checker accepts the head record.
- out_hartid, out_pc, out_inst, out_wdata  out  8/XLEN/32/XLEN  Fields of the head record.
- count  out  $clog2(DEPTH)+1  Number of occupied slots.
- err_overflow  out  1  Sticky: a record was dropped.
- err_orphan  out  1  Sticky: a long-latency writeback matched no pending record.
- err_timeout  out  1  Sticky: the pending head exceeded TIMEOUT cycles.

## Operation
- Storage is a circular buffer with head and tail pointers. Each slot holds hartid, pc, inst, wdata, rd and a pending bit.
- **Push.** When `in_valid` is asserted and a slot is free after this cycle's pop, the record is written at the tail.
  - pending = `in_wait` && (`in_rd` != 0).
  - If pending, wdata is stored as 0.
- **Pop.** A pop occurs when `out_valid` && `out_ready`; the head then advances.
- **Output.** `out_valid` = (count != 0) && !head.pending. The out_* ports are driven combinationally from the head slot.
- **Long-latency fill.** On `ll_wen`, the oldest pending slot whose rd = `ll_waddr` receives `ll_wdata` and its pending bit clears.
  - The search runs from head to tail, among entries present before this cycle's push.
  - If no slot matches, `err_orphan` is set and the data is discarded.
  - If `ll_waddr` = 0, the writeback is ignored and no error is raised.
- **Full.** `in_valid` while count = DEPTH and no pop this cycle: the record is dropped and `err_overflow` is set.
  - Push and pop in the same cycle while full are both accepted.
- **Count.** count = count + push − pop, with no wrap; it stays within 0..DEPTH.
- **Reset.** Pointers clear, count = 0 and all pending bits are 0. `out_valid`, all err_* outputs and the watchdog counter are 0. The out_* data ports show slot 0 contents, which are don't-care while `out_valid` = 0.
- **Reset mid-operation.** All queued records are discarded.

## Timing
- Record pushed complete at cycle N: `out_valid` is asserted at N+1 if it is at the head.
- Pending record filled at cycle M: `out_valid` for it is asserted at M+1 at the earliest.
- Same-cycle `ll_wen` and push of the matching record: the writeback does not hit the new record, and `err_orphan` is set.
- Sticky errors assert on the cycle after the causing event and clear only on reset.
- Throughput is one push and one pop per cycle. No combinational path exists from `in_*` to `out_valid`.
- Head-of-line blocking: a pending head stalls younger complete records.

## Configuration
- `COMMIT_TRACE_QUEUE_TIMEOUT_EN` defined:
  - A counter increments each cycle that count != 0 and the head is pending, and resets on any head change or fill.
  - Reaching TIMEOUT sets `err_timeout`.
- Macro undefined: no counter is instantiated and `err_timeout` is tied to 0.

## Test plan
- Reset (reset=0) with 3 records in flight -> next cycle count=0, `out_valid`=0, all errors 0.
- Push pc=0x80000000 (wdata=0x5) with `out_ready`=1 -> `out_valid` next cycle, out_wdata=0x5, count returns to 0.
- Push load rd=10 `in_wait`=1, then ALU rd=11; `ll_wen` rd=10 data=0xDEAD three cycles later -> the load is emitted first with wdata 0xDEAD, then the ALU record, in order.
- Two pending records rd=5 and `ll_wen` rd=5 twice with 0x1 then 0x2 -> the older record gets 0x1 and the younger gets 0x2.
- `out_ready`=0 and DEPTH+1 pushes -> count=DEPTH and `err_overflow`=1. Then a push with pop while full -> both accepted, count unchanged.
- With macro defined and TIMEOUT=8: pending head and no `ll_wen` -> `err_timeout`=1 after 8 cycles. Without the macro it stays 0. Separately, `ll_wen` rd=7 with no pending records -> `err_orphan`=1.
